uart_tx_fifo: RTL

- Transmit-side buffer and sequencer directly upstream of the UART core (as_uart).
- Accepts byte writes from the CPU bus side into a synchronous FIFO.
- Drains the FIFO one byte at a time into the UART core's start_i/data_i, pacing on its rdy_tx_o.
- Lets software burst up to DEPTH bytes without polling the transmitter per byte.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 76 +++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU write port, FIFO status flags and UART-core start/ready handshake
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    logic                     wr_i;
    logic [WIDTH-1:0]         wdata_i;
    logic                     clr_ovf_i;
    logic                     full_o;
    logic                     empty_o;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     overflow_o;
    logic                     busy_o;
    logic                     start_o;
    logic [WIDTH-1:0]         data_o;
    logic                     rdy_tx_i;

    modport slave (
        input  wr_i, wdata_i, clr_ovf_i, rdy_tx_i,
        output full_o, empty_o, level_o, overflow_o, busy_o, start_o, data_o
    );

    modport master (
        output wr_i, wdata_i, clr_ovf_i, rdy_tx_i,
        input  full_o, empty_o, level_o, overflow_o, busy_o, start_o, data_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART core, issuing one start pulse per byte paced on rdy_tx
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      level_q, level_d;
    logic             full_q, empty_q, ovf_q, start_q, busy_q;
    logic [WIDTH-1:0] data_q;
    logic             pop, push;

    // A pop frees a slot in the same cycle, so a write to a full FIFO is still accepted then
    assign pop  = state_q == IDLE && !empty_q && bus.rdy_tx_i;
    assign push = bus.wr_i && (!full_q || pop);

    always_comb level_d = level_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk_i)
        if (push) mem_q[wr_q] <= bus.wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            rd_q    <= rd_q + AW'(pop);
            wr_q    <= wr_q + AW'(push);
            level_q <= level_d;
            full_q  <= level_d == LVL_FULL;
            empty_q <= level_d == 0;
            ovf_q   <= (bus.wr_i && full_q && !pop) || (ovf_q && !bus.clr_ovf_i);
            start_q <= pop;
            case (state_q)
                IDLE: if (pop) begin
                    data_q  <= mem_q[rd_q];
                    busy_q  <= 1'b1;
                    state_q <= START;
                end
                START:     state_q <= WAIT_BUSY;
                WAIT_BUSY: if (!bus.rdy_tx_i) state_q <= WAIT_DONE;
                WAIT_DONE: if (bus.rdy_tx_i) begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.level_o    = level_q;
    assign bus.overflow_o = ovf_q;
    assign bus.busy_o     = busy_q;
    assign bus.start_o    = start_q;
    assign bus.data_o     = data_q;
endmodule
